// File: rtl/swap_frame_buffer.sv
// rtl/swap_frame_buffer.sv - double-buffered upscaling frame buffer, optional clear via SWAP_FRAME_BUFFER_CLEAR_EN
module swap_frame_buffer #(
    parameter int          FB_WIDTH    = 320,
    parameter int          FB_HEIGHT   = 180,
    parameter int          SCALE_SHIFT = 2,
    parameter int          H_TOTAL     = 1280,
    parameter int          V_TOTAL     = 720,
    parameter logic [15:0] CLEAR_COLOR = 16'h0000,
    localparam int         FB_DEPTH    = FB_WIDTH * FB_HEIGHT,
    localparam int         ADDR_W      = $clog2(FB_DEPTH),
    localparam int         H_W         = $clog2(H_TOTAL),
    localparam int         V_W         = $clog2(V_TOTAL)
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic [15:0]       write_data_in,
    input  logic [ADDR_W-1:0] write_addr_in,
    input  logic              write_valid_in,
    output logic              write_ready_out,
    input  logic              swap_req_in,
    output logic              swap_pending_out,
    output logic              swap_done_out,
    output logic              front_sel_out,
    input  logic [H_W-1:0]    hcount_in,
    input  logic [V_W-1:0]    vcount_in,
    input  logic              active_in,
    output logic [7:0]        red_out,
    output logic [7:0]        green_out,
    output logic [7:0]        blue_out,
    output logic              pixel_valid_out
);

`ifdef SWAP_FRAME_BUFFER_CLEAR_EN
    typedef enum logic [1:0] {IDLE, PENDING, CLEAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, PENDING} state_t;
`endif

    state_t state_q, state_d;
    logic   commit;
    logic   front_sel_q;
    logic   swap_done_q;
    logic   frame_end;

    logic [15:0] mem0 [FB_DEPTH];
    logic [15:0] mem1 [FB_DEPTH];

    logic [31:0]       col, row, lin;
    logic              in_range;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              rd_bank_q, rd_ok_q, act1_q;
    logic              bank2_q, ok2_q, pixel_valid_q;
    logic [15:0]       rd0_q, rd1_q, pix;

    logic              clearing;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;

`ifdef SWAP_FRAME_BUFFER_CLEAR_EN
    logic [ADDR_W-1:0] clr_addr_q;
    logic              req_latched_q;
    assign clearing = (state_q == CLEAR);
`else
    assign clearing = 1'b0;
`endif

    assign frame_end = (hcount_in == H_W'(H_TOTAL - 1)) && (vcount_in == V_W'(V_TOTAL - 1));

    // Map raster coordinates onto the low-resolution store and flag anything outside it.
    always_comb begin
        col      = 32'(hcount_in >> SCALE_SHIFT);
        row      = 32'(vcount_in >> SCALE_SHIFT);
        in_range = (col < 32'(FB_WIDTH)) && (row < 32'(FB_HEIGHT));
        lin      = row * 32'(FB_WIDTH) + col;
    end

    // Read stage 1: register address, displayed bank and qualifiers together so a swap cannot split them.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rd_addr_q <= '0;
            rd_bank_q <= 1'b0;
            rd_ok_q   <= 1'b0;
            act1_q    <= 1'b0;
        end else begin
            rd_addr_q <= in_range ? ADDR_W'(lin) : '0;
            rd_bank_q <= front_sel_q;
            rd_ok_q   <= active_in && in_range;
            act1_q    <= active_in;
        end
    end

    // Read stage 2: RAM output registers, kept reset-free so they map onto block RAM.
    always_ff @(posedge clk_in) begin
        rd0_q <= mem0[rd_addr_q];
        rd1_q <= mem1[rd_addr_q];
    end

    // Read stage 2 control: qualifiers travel alongside the RAM data.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            bank2_q       <= 1'b0;
            ok2_q         <= 1'b0;
            pixel_valid_q <= 1'b0;
        end else begin
            bank2_q       <= rd_bank_q;
            ok2_q         <= rd_ok_q;
            pixel_valid_q <= act1_q;
        end
    end

    // RGB565 to RGB888 by MSB replication; blanked when inactive or outside the store.
    always_comb begin
        pix       = bank2_q ? rd1_q : rd0_q;
        red_out   = ok2_q ? {pix[15:11], pix[15:13]} : 8'h00;
        green_out = ok2_q ? {pix[10:5],  pix[10:9]}  : 8'h00;
        blue_out  = ok2_q ? {pix[4:0],   pix[4:2]}   : 8'h00;
    end

    // Write port mux: the clear sweep owns the back bank while it runs; oversized addresses are dropped.
    always_comb begin
        wr_en   = write_valid_in && (32'(write_addr_in) < 32'(FB_DEPTH));
        wr_addr = write_addr_in;
        wr_data = clearing ? CLEAR_COLOR : write_data_in;
`ifdef SWAP_FRAME_BUFFER_CLEAR_EN
        if (clearing) begin
            wr_en   = 1'b1;
            wr_addr = clr_addr_q;
        end
`endif
    end

    // Back-bank writes; front_sel is the pre-commit value, so a commit-cycle write lands in the old back bank.
    always_ff @(posedge clk_in) begin
        if (wr_en && !front_sel_q) mem1[wr_addr] <= wr_data;
        if (wr_en &&  front_sel_q) mem0[wr_addr] <= wr_data;
    end

    // Swap FSM state register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // Swap FSM next state: a request coinciding with frame end commits immediately.
    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (swap_req_in) begin
                    if (frame_end) commit  = 1'b1;
                    else           state_d = PENDING;
                end
            end
            PENDING: begin
                if (frame_end) commit = 1'b1;
            end
`ifdef SWAP_FRAME_BUFFER_CLEAR_EN
            CLEAR: begin
                if (clr_addr_q == ADDR_W'(FB_DEPTH - 1))
                    state_d = (req_latched_q || swap_req_in) ? PENDING : IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
`ifdef SWAP_FRAME_BUFFER_CLEAR_EN
        if (commit) state_d = CLEAR;
`else
        if (commit) state_d = IDLE;
`endif
    end

    // Bank select flips on the commit edge; swap_done follows as a one-cycle pulse.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            front_sel_q <= 1'b0;
            swap_done_q <= 1'b0;
        end else begin
            front_sel_q <= front_sel_q ^ commit;
            swap_done_q <= commit;
        end
    end

`ifdef SWAP_FRAME_BUFFER_CLEAR_EN
    // Clear sweep address and a latch for requests that arrive mid-sweep.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            clr_addr_q    <= '0;
            req_latched_q <= 1'b0;
        end else begin
            if (commit)        clr_addr_q <= '0;
            else if (clearing) clr_addr_q <= clr_addr_q + 1'b1;
            if (!clearing)        req_latched_q <= 1'b0;
            else if (swap_req_in) req_latched_q <= 1'b1;
        end
    end
`endif

    assign write_ready_out  = !clearing;
    assign swap_pending_out = (state_q == PENDING);
    assign swap_done_out    = swap_done_q;
    assign front_sel_out    = front_sel_q;
    assign pixel_valid_out  = pixel_valid_q;

endmodule

// File: tb/tb_swap_frame_buffer.sv
// tb/tb_swap_frame_buffer.sv - self-checking bench for swap_frame_buffer
module tb_swap_frame_buffer;
    localparam int FB_WIDTH  = 320;
    localparam int FB_HEIGHT = 180;
    localparam int SHIFT     = 2;
    localparam int H_TOTAL   = 1280;
    localparam int V_TOTAL   = 720;
    localparam int FB_DEPTH  = FB_WIDTH * FB_HEIGHT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] write_data;
    logic [15:0] write_addr;
    logic        write_valid;
    logic        write_ready;
    logic        swap_req;
    logic        swap_pending;
    logic        swap_done;
    logic        front_sel;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        active;
    logic [7:0]  red, green, blue;
    logic        pixel_valid;

    int errors = 0;
    int checks = 0;

    logic [15:0] model_mem [int];
    bit          model_front;

    swap_frame_buffer #(
        .FB_WIDTH(FB_WIDTH), .FB_HEIGHT(FB_HEIGHT), .SCALE_SHIFT(SHIFT),
        .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL), .CLEAR_COLOR(16'h0000)
    ) dut (
        .clk_in(clk), .rst_n_in(rst_n),
        .write_data_in(write_data), .write_addr_in(write_addr),
        .write_valid_in(write_valid), .write_ready_out(write_ready),
        .swap_req_in(swap_req), .swap_pending_out(swap_pending),
        .swap_done_out(swap_done), .front_sel_out(front_sel),
        .hcount_in(hcount), .vcount_in(vcount), .active_in(active),
        .red_out(red), .green_out(green), .blue_out(blue),
        .pixel_valid_out(pixel_valid)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] expand(input logic [15:0] p);
        int r, g, b;
        r = int'(p) / 2048;
        g = (int'(p) / 32) % 64;
        b = int'(p) % 32;
        return {8'(r * 8 + r / 4), 8'(g * 4 + g / 16), 8'(b * 8 + b / 4)};
    endfunction

    function automatic logic [23:0] expected_rgb(input int h, input int v, input bit act);
        int c, r, key;
        c = h / (1 << SHIFT);
        r = v / (1 << SHIFT);
        if (!act || c >= FB_WIDTH || r >= FB_HEIGHT) return 24'h0;
        key = int'(model_front) * FB_DEPTH + r * FB_WIDTH + c;
        if (!model_mem.exists(key)) return 24'hxxxxxx;
        return expand(model_mem[key]);
    endfunction

    task automatic do_write(input int addr, input logic [15:0] data);
        write_addr  = 16'(addr);
        write_data  = data;
        write_valid = 1'b1;
        check("write_ready", write_ready, 1);
        tick;
        write_valid = 1'b0;
        if (addr < FB_DEPTH) model_mem[int'(!model_front) * FB_DEPTH + addr] = data;
    endtask

    task automatic do_read(input string tag, input int h, input int v, input bit act);
        hcount = 11'(h);
        vcount = 10'(v);
        active = act;
        tick;
        tick;
        check(tag, {red, green, blue}, expected_rgb(h, v, act));
        check({tag, "_pv"}, pixel_valid, act);
        active = 1'b0;
    endtask

    task automatic frame_end_inputs;
        hcount = 11'(H_TOTAL - 1);
        vcount = 10'(V_TOTAL - 1);
    endtask

    task automatic do_swap(input string tag);
        hcount = 0; vcount = 0;
        swap_req = 1'b1;
        tick;
        swap_req = 1'b0;
        check({tag, "_pending"}, swap_pending, 1);
        check({tag, "_front_hold"}, front_sel, model_front);
        frame_end_inputs();
        tick;
        model_front = !model_front;
        check({tag, "_done"}, swap_done, 1);
        check({tag, "_front"}, front_sel, model_front);
        check({tag, "_pending_clr"}, swap_pending, 0);
        hcount = 0; vcount = 0;
        tick;
        check({tag, "_done_pulse"}, swap_done, 0);
    endtask

    initial begin
        int done_cnt;
        bit f0;
        rst_n = 1'b0; write_data = '0; write_addr = '0; write_valid = 1'b0;
        swap_req = 1'b0; hcount = '0; vcount = '0; active = 1'b0;
        model_front = 1'b0;
        tick; tick;
        rst_n = 1'b1;
        tick;
        check("rst_front", front_sel, 0);
        check("rst_pending", swap_pending, 0);
        check("rst_done", swap_done, 0);
        check("rst_ready", write_ready, 1);
        check("rst_pv", pixel_valid, 0);
        check("rst_rgb", {red, green, blue}, 0);

        // Fill a small region of both banks so every region read has a known value.
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 8; c++) do_write(r * FB_WIDTH + c, 16'($urandom));
        do_swap("init_swap");
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 8; c++) do_write(r * FB_WIDTH + c, 16'($urandom));

        // Pure red at addr 0 covers a 4x4 raster block.
        do_write(0, 16'hF800);
        do_swap("red_swap");
        for (int v = 0; v < 4; v++)
            for (int h = 0; h < 4; h++) do_read("red_blk", h, v, 1'b1);
        check("red_literal", {red, green, blue}, 24'hFF0000);

        do_write(321, 16'h07E0);
        do_swap("green_swap");
        do_read("green_44", 4, 4, 1'b1);
        check("green_literal", green, 8'hFF);
        do_read("green_30", 3, 0, 1'b1);

        // Write while pending stays invisible until the commit edge.
        hcount = 0; vcount = 0;
        swap_req = 1'b1; tick; swap_req = 1'b0;
        check("pw_pending", swap_pending, 1);
        do_write(5, 16'h001F);
        do_read("pw_before", 20, 0, 1'b1);
        check("pw_front_hold", front_sel, model_front);
        frame_end_inputs(); tick;
        model_front = !model_front;
        check("pw_done", swap_done, 1);
        check("pw_front", front_sel, model_front);
        hcount = 0; vcount = 0; tick;
        check("pw_done_once", swap_done, 0);
        do_read("pw_after", 20, 0, 1'b1);
        check("pw_blue_literal", blue, 8'hFF);

        // Three requests in one frame coalesce into one swap.
        hcount = 0; vcount = 0;
        for (int i = 0; i < 3; i++) begin
            swap_req = 1'b1; tick; swap_req = 1'b0; tick;
        end
        check("coal_pending", swap_pending, 1);
        done_cnt = 0;
        frame_end_inputs(); tick;
        done_cnt += int'(swap_done);
        hcount = 0; vcount = 0;
        for (int i = 0; i < 4; i++) begin tick; done_cnt += int'(swap_done); end
        model_front = !model_front;
        check("coal_done_cnt", done_cnt, 1);
        check("coal_front", front_sel, model_front);
        check("coal_idle", swap_pending, 0);

        // Request arriving on the frame-end cycle in IDLE commits there.
        swap_req = 1'b1; frame_end_inputs(); tick;
        swap_req = 1'b0; hcount = 0; vcount = 0;
        model_front = !model_front;
        check("same_cyc_front", front_sel, model_front);
        check("same_cyc_done", swap_done, 1);
        tick;

        // Commit-cycle write lands in the old back bank, which becomes the front.
        swap_req = 1'b1; tick; swap_req = 1'b0;
        frame_end_inputs();
        write_addr = 16'd6; write_data = 16'h1234; write_valid = 1'b1;
        tick;
        write_valid = 1'b0;
        model_mem[int'(!model_front) * FB_DEPTH + 6] = 16'h1234;
        model_front = !model_front;
        hcount = 0; vcount = 0; tick;
        do_read("commit_wr", 24, 0, 1'b1);

        // Held request swaps at every frame end.
        f0 = model_front;
        done_cnt = 0;
        swap_req = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i == 3 || i == 8) frame_end_inputs();
            else begin hcount = 0; vcount = 0; end
            if (i == 8) swap_req = 1'b0;
            tick;
            done_cnt += int'(swap_done);
        end
        hcount = 0; vcount = 0;
        check("held_done_cnt", done_cnt, 2);
        check("held_front", front_sel, f0);
        check("held_idle", swap_pending, 0);

        // Boundary addresses and out-of-range raster.
        do_write(FB_DEPTH - 1, 16'hA5C3);
        do_write(FB_DEPTH, 16'hFFFF);
        do_swap("bound_swap");
        do_read("last_addr", H_TOTAL - 1, V_TOTAL - 1, 1'b1);
        check("last_no_swap", front_sel, model_front);
        do_read("h_oob", H_TOTAL, 0, 1'b1);
        do_read("v_oob", 0, V_TOTAL, 1'b1);
        do_read("inactive", 0, 0, 1'b0);
        do_read("addr0_keep", 0, 0, 1'b1);

        // Random mix against the model.
        for (int n = 0; n < 80; n++) begin
            int op;
            op = int'($urandom_range(0, 9));
            if (op <= 3)
                do_write(int'($urandom_range(0, 3)) * FB_WIDTH + int'($urandom_range(0, 7)), 16'($urandom));
            else if (op <= 7)
                do_read("rnd_rd", int'($urandom_range(0, 31)), int'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
            else if (op == 8) begin
                if ($urandom_range(0, 1) == 1)
                    do_read("rnd_oob", int'($urandom_range(H_TOTAL, 2047)), int'($urandom_range(0, V_TOTAL - 1)), 1'b1);
                else
                    do_read("rnd_oob", int'($urandom_range(0, H_TOTAL - 1)), int'($urandom_range(V_TOTAL, 1023)), 1'b1);
            end else
                do_swap("rnd_swap");
        end

        // Reset mid-frame with a swap pending.
        if (!model_front) do_swap("pre_rst_swap");
        hcount = 0; vcount = 0;
        swap_req = 1'b1; tick; swap_req = 1'b0;
        rst_n = 1'b0;
        #1;
        check("arst_front", front_sel, 0);
        check("arst_ready", write_ready, 1);
        check("arst_pending", swap_pending, 0);
        check("arst_done", swap_done, 0);
        tick;
        rst_n = 1'b1;
        model_front = 1'b0;
        tick;
        do_read("post_rst", 8, 4, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
